// File: rtl/alt_scaler_regs_pkg.sv
// Register map, reset values and response codes for the alt_scaler control port.
package alt_scaler_regs_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_SRC_SIZE = 2'd1,
    REG_DST_SIZE = 2'd2,
    REG_SCALE    = 2'd3
  } reg_idx_e;

  localparam logic [DATA_W-1:0] REG_RST_VAL = '0;
  localparam logic [1:0]        RESP_OKAY   = 2'b00;

  // Merge new data into an old word, byte lane by byte lane, under a strobe mask.
  function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] new_val,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/alt_scaler_ctrl_s_axi_if.sv
// AXI4-Lite bundle for the alt_scaler S00_AXI control port.
interface alt_scaler_ctrl_s_axi_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/alt_scaler_axil_wr.sv
// AXI4-Lite write channel: captures AW and W independently, issues one
// register-file write strobe once both are held, then owns the B response.
module alt_scaler_axil_wr
  import alt_scaler_regs_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_armed,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready,
  output logic              o_wr_en,
  output reg_idx_e          o_wr_idx,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [STRB_W-1:0] o_wr_strb
);

  logic              r_aw_held;
  reg_idx_e          r_aw_idx;
  logic              r_w_held;
  logic [DATA_W-1:0] r_w_data;
  logic [STRB_W-1:0] r_w_strb;
  logic              r_bvalid;

  logic w_aw_fire;
  logic w_w_fire;
  logic w_commit;
  logic w_unused_addr;

  assign o_awready = i_armed & ~r_aw_held & ~r_bvalid;
  assign o_wready  = i_armed & ~r_w_held  & ~r_bvalid;
  assign w_aw_fire = i_awvalid & o_awready;
  assign w_w_fire  = i_wvalid  & o_wready;
  assign w_commit  = r_aw_held & r_w_held;

  assign o_bresp   = RESP_OKAY;
  assign o_bvalid  = r_bvalid;
  assign o_wr_en   = w_commit;
  assign o_wr_idx  = r_aw_idx;
  assign o_wr_data = r_w_data;
  assign o_wr_strb = r_w_strb;

  assign w_unused_addr = &{1'b0, i_awaddr[1:0]};

  // Hold each channel until its partner arrives; commit clears both and raises BVALID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= REG_CTRL;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
    end else begin
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= reg_idx_e'(i_awaddr[3:2]);
      end
      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_w_data <= i_wdata;
        r_w_strb <= i_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
      end else if (r_bvalid && i_bready) begin
        r_bvalid  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alt_scaler_ctrl_s_axi.sv
// alt_scaler control port: shadow register file written over AXI4-Lite,
// active copies loaded from the shadows only on frame_sync.
module alt_scaler_ctrl_s_axi
  import alt_scaler_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  alt_scaler_ctrl_s_axi_if.slave        s_axi,
  input  logic                          frame_sync,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg3,
  output logic                          cfg_updated
);

  logic              r_armed;
  logic [DATA_W-1:0] r_shadow [NUM_REGS];
  logic [DATA_W-1:0] r_active [NUM_REGS];
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_cfg_updated;

  logic              w_wr_en;
  reg_idx_e          w_wr_idx;
  logic [DATA_W-1:0] w_wr_data;
  logic [STRB_W-1:0] w_wr_strb;
  logic              w_ar_fire;
  reg_idx_e          w_ar_idx;
  logic              w_unused_ok;

  alt_scaler_axil_wr #(
    .ADDR_W (C_S_AXI_ADDR_WIDTH)
  ) u_wr (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .i_armed   (r_armed),
    .i_awaddr  (s_axi.S_AXI_AWADDR),
    .i_awvalid (s_axi.S_AXI_AWVALID),
    .o_awready (s_axi.S_AXI_AWREADY),
    .i_wdata   (s_axi.S_AXI_WDATA),
    .i_wstrb   (s_axi.S_AXI_WSTRB),
    .i_wvalid  (s_axi.S_AXI_WVALID),
    .o_wready  (s_axi.S_AXI_WREADY),
    .o_bresp   (s_axi.S_AXI_BRESP),
    .o_bvalid  (s_axi.S_AXI_BVALID),
    .i_bready  (s_axi.S_AXI_BREADY),
    .o_wr_en   (w_wr_en),
    .o_wr_idx  (w_wr_idx),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb)
  );

  assign s_axi.S_AXI_ARREADY = r_armed & ~r_rvalid;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;

  assign w_ar_fire = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
  assign w_ar_idx  = reg_idx_e'(s_axi.S_AXI_ARADDR[3:2]);

  assign cfg_reg0    = r_active[REG_CTRL];
  assign cfg_reg1    = r_active[REG_SRC_SIZE];
  assign cfg_reg2    = r_active[REG_DST_SIZE];
  assign cfg_reg3    = r_active[REG_SCALE];
  assign cfg_updated = r_cfg_updated;

  assign w_unused_ok = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_ARADDR[1:0]};

  // Keep every ready low until the first edge after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_armed <= 1'b0;
    else                r_armed <= 1'b1;
  end

  // Shadow register file, byte-lane writes from the write channel.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_shadow[i] <= REG_RST_VAL;
    end else if (w_wr_en) begin
      r_shadow[w_wr_idx] <= apply_wstrb(r_shadow[w_wr_idx], w_wr_data, w_wr_strb);
    end
  end

  // Read channel; samples the shadow before any same-edge write lands.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= r_shadow[w_ar_idx];
    end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Frame-boundary commit of all shadows into the active copies, flagged one cycle later.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_active[i] <= REG_RST_VAL;
      r_cfg_updated <= 1'b0;
    end else begin
      r_cfg_updated <= frame_sync;
      if (frame_sync) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_alt_scaler_ctrl_s_axi.sv
// Self-checking bench for alt_scaler_ctrl_s_axi against a register-array model.
module tb_alt_scaler_ctrl_s_axi;

  localparam int MAXW = 50;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_sync;
  logic [31:0] cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3;
  logic cfg_updated;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_shadow [4];
  logic [31:0] m_active [4];

  alt_scaler_ctrl_s_axi_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

  alt_scaler_ctrl_s_axi #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .frame_sync    (frame_sync),
    .cfg_reg0      (cfg_reg0),
    .cfg_reg1      (cfg_reg1),
    .cfg_reg2      (cfg_reg2),
    .cfg_reg3      (cfg_reg3),
    .cfg_updated   (cfg_updated)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cfg_of(input int i);
    case (i)
      0: return cfg_reg0;
      1: return cfg_reg1;
      2: return cfg_reg2;
      default: return cfg_reg3;
    endcase
  endfunction

  // Model: every strobed byte takes the new value, others keep theirs.
  task automatic m_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) m_shadow[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 32'h0;
      m_active[i] = 32'h0;
    end
  endtask

  // Raise the requested valids and wait until each is accepted.
  task automatic drive_aw_w(input bit do_aw, input bit do_w);
    int n;
    bit aw_f, w_f;
    n = 0;
    if (do_aw) axi.S_AXI_AWVALID = 1'b1;
    if (do_w)  axi.S_AXI_WVALID  = 1'b1;
    while ((axi.S_AXI_AWVALID || axi.S_AXI_WVALID) && n < MAXW) begin
      @(negedge clk);
      aw_f = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_f  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge clk); #1;
      if (aw_f) axi.S_AXI_AWVALID = 1'b0;
      if (w_f)  axi.S_AXI_WVALID  = 1'b0;
      n++;
    end
    if (axi.S_AXI_AWVALID || axi.S_AXI_WVALID) begin
      n_cmp++; n_bad++;
      $display("FAIL aw_w_timeout: awvalid=%0b wvalid=%0b still pending after %0d cycles, required accepted",
               axi.S_AXI_AWVALID, axi.S_AXI_WVALID, MAXW);
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit fsync_at_commit, output logic [1:0] bresp);
    int n;
    bit got;
    axi.S_AXI_AWADDR = addr;
    axi.S_AXI_WDATA  = data;
    axi.S_AXI_WSTRB  = strb;
    axi.S_AXI_BREADY = 1'b1;
    drive_aw_w(1'b1, 1'b1);
    if (fsync_at_commit) frame_sync = 1'b1;
    bresp = 2'b11;
    got = 1'b0;
    n = 0;
    while (!got && n < MAXW) begin
      @(negedge clk);
      if (axi.S_AXI_BVALID) begin
        got = 1'b1;
        bresp = axi.S_AXI_BRESP;
      end
      @(posedge clk); #1;
      frame_sync = 1'b0;
      n++;
    end
    axi.S_AXI_BREADY = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL bvalid_timeout: no BVALID within %0d cycles, required BVALID", MAXW);
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] rresp);
    int n;
    bit ar_f, got;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY  = 1'b1;
    n = 0;
    while (axi.S_AXI_ARVALID && n < MAXW) begin
      @(negedge clk);
      ar_f = axi.S_AXI_ARREADY;
      @(posedge clk); #1;
      if (ar_f) axi.S_AXI_ARVALID = 1'b0;
      n++;
    end
    data = 32'hx;
    rresp = 2'b11;
    got = axi.S_AXI_ARVALID ? 1'b0 : 1'b0;
    n = axi.S_AXI_ARVALID ? MAXW : 0;
    axi.S_AXI_ARVALID = 1'b0;
    while (!got && n < MAXW) begin
      @(negedge clk);
      if (axi.S_AXI_RVALID) begin
        got = 1'b1;
        data = axi.S_AXI_RDATA;
        rresp = axi.S_AXI_RRESP;
      end
      @(posedge clk); #1;
      n++;
    end
    axi.S_AXI_RREADY = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL read_timeout: no AR accept or RVALID within %0d cycles, required RVALID", MAXW);
    end
  endtask

  task automatic pulse_fsync();
    frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ready: got %b required 000",
               {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY});
    end
    n_cmp++;
    if ({axi.S_AXI_BVALID, axi.S_AXI_RVALID, cfg_updated, axi.S_AXI_BRESP, axi.S_AXI_RRESP} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_valid_resp: got %b required 0000000",
               {axi.S_AXI_BVALID, axi.S_AXI_RVALID, cfg_updated, axi.S_AXI_BRESP, axi.S_AXI_RRESP});
    end
    n_cmp++;
    if ({cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3, axi.S_AXI_RDATA} !== 160'h0) begin
      n_bad++;
      $display("FAIL reset_data: cfg %h %h %h %h rdata %h required all 0",
               cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3, axi.S_AXI_RDATA);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (axi.S_AXI_AWREADY !== 1'b0) begin
      n_bad++;
      $display("FAIL unarmed_awready: got %b required 0", axi.S_AXI_AWREADY);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b111) begin
      n_bad++;
      $display("FAIL armed_ready: got %b required 111",
               {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY});
    end
    m_reset();
  endtask

  task automatic test_readback();
    logic [31:0] vals [4];
    logic [31:0] rd;
    logic [1:0]  resp;
    vals = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), vals[i], 4'hF, 1'b0, resp);
      m_write(i, vals[i], 4'hF);
      n_cmp++;
      if (resp !== 2'b00) begin
        n_bad++;
        $display("FAIL readback_bresp[%0d]: got %b required 00", i, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, resp);
      n_cmp++;
      if (rd !== m_shadow[i] || resp !== 2'b00) begin
        n_bad++;
        $display("FAIL readback[%0d]: got %h/%b required %h/00", i, rd, resp, m_shadow[i]);
      end
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd;
    logic [1:0]  resp;
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 1'b0, resp);
    m_write(1, 32'hFFFFFFFF, 4'hF);
    axi_write(4'h4, 32'h12345678, 4'b0101, 1'b0, resp);
    m_write(1, 32'h12345678, 4'b0101);
    axi_read(4'h4, rd, resp);
    n_cmp++;
    if (rd !== 32'hFF34FF78) begin
      n_bad++;
      $display("FAIL strobe_readback: got %h required ff34ff78", rd);
    end
  endtask

  task automatic test_channel_order();
    logic [31:0] d, rd;
    logic [1:0]  resp;
    for (int ord = 0; ord < 2; ord++) begin
      d = $urandom;
      axi.S_AXI_AWADDR = 4'hC;
      axi.S_AXI_WDATA  = d;
      axi.S_AXI_WSTRB  = 4'hF;
      axi.S_AXI_BREADY = 1'b0;
      drive_aw_w(ord == 1, ord == 0);
      repeat (2) @(posedge clk);
      #1;
      drive_aw_w(ord == 0, ord == 1);
      m_write(3, d, 4'hF);
      n_cmp++;
      if (axi.S_AXI_BVALID !== 1'b0) begin
        n_bad++;
        $display("FAIL order%0d_bvalid_early: got %b required 0", ord, axi.S_AXI_BVALID);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (axi.S_AXI_BVALID !== 1'b1) begin
        n_bad++;
        $display("FAIL order%0d_bvalid_latency: got %b required 1", ord, axi.S_AXI_BVALID);
      end
      for (int c = 0; c < 5; c++) begin
        n_cmp++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 3'b100) begin
          n_bad++;
          $display("FAIL order%0d_bhold[%0d]: bvalid/awready/wready got %b required 100", ord, c,
                   {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY});
        end
        @(posedge clk); #1;
      end
      axi.S_AXI_BREADY = 1'b1;
      @(posedge clk); #1;
      axi.S_AXI_BREADY = 1'b0;
      n_cmp++;
      if ({axi.S_AXI_BVALID, axi.S_AXI_AWREADY} !== 2'b01) begin
        n_bad++;
        $display("FAIL order%0d_bdone: bvalid/awready got %b required 01", ord,
                 {axi.S_AXI_BVALID, axi.S_AXI_AWREADY});
      end
      axi_read(4'hC, rd, resp);
      n_cmp++;
      if (rd !== m_shadow[3]) begin
        n_bad++;
        $display("FAIL order%0d_readback: got %h required %h", ord, rd, m_shadow[3]);
      end
    end
  endtask

  task automatic test_shadow_active();
    logic [1:0] resp;
    axi_write(4'h8, 32'h00000500, 4'hF, 1'b0, resp);
    m_write(2, 32'h00000500, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (cfg_reg2 !== m_active[2] || cfg_updated !== 1'b0) begin
      n_bad++;
      $display("FAIL no_fsync_cfg2: got %h/%b required %h/0", cfg_reg2, cfg_updated, m_active[2]);
    end
    pulse_fsync();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cfg_of(i) !== m_active[i]) begin
        n_bad++;
        $display("FAIL fsync_cfg%0d: got %h required %h", i, cfg_of(i), m_active[i]);
      end
    end
    n_cmp++;
    if (cfg_reg2 !== 32'h00000500 || cfg_updated !== 1'b1) begin
      n_bad++;
      $display("FAIL fsync_cfg2_updated: got %h/%b required 00000500/1", cfg_reg2, cfg_updated);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (cfg_updated !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_updated_width: got %b required 0", cfg_updated);
    end
  endtask

  task automatic test_write_fsync();
    logic [1:0] resp;
    for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
    axi_write(4'h0, 32'hA5A5A5A5, 4'hF, 1'b1, resp);
    m_write(0, 32'hA5A5A5A5, 4'hF);
    n_cmp++;
    if (cfg_reg0 !== m_active[0]) begin
      n_bad++;
      $display("FAIL coincident_cfg0: got %h required %h", cfg_reg0, m_active[0]);
    end
    pulse_fsync();
    n_cmp++;
    if (cfg_reg0 !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL next_fsync_cfg0: got %h required a5a5a5a5", cfg_reg0);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, rd;
    logic [3:0]  s;
    logic [1:0]  resp;
    int idx, op;
    for (int k = 0; k < 40; k++) begin
      op  = $urandom_range(0, 2);
      idx = $urandom_range(0, 3);
      if (op == 0) begin
        d = $urandom;
        s = 4'($urandom);
        axi_write(4'(idx * 4) | 4'($urandom_range(0, 3)), d, s, 1'b0, resp);
        m_write(idx, d, s);
        n_cmp++;
        if (resp !== 2'b00) begin
          n_bad++;
          $display("FAIL rand_bresp[%0d]: got %b required 00", k, resp);
        end
      end else if (op == 1) begin
        axi_read(4'(idx * 4), rd, resp);
        n_cmp++;
        if (rd !== m_shadow[idx] || resp !== 2'b00) begin
          n_bad++;
          $display("FAIL rand_read[%0d] reg%0d: got %h/%b required %h/00", k, idx, rd, resp, m_shadow[idx]);
        end
      end else begin
        pulse_fsync();
        n_cmp++;
        if ({cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3} !== {m_active[0], m_active[1], m_active[2], m_active[3]}) begin
          n_bad++;
          $display("FAIL rand_commit[%0d]: got %h %h %h %h required %h %h %h %h", k,
                   cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3,
                   m_active[0], m_active[1], m_active[2], m_active[3]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [1:0]  resp;
    pulse_fsync();
    axi.S_AXI_AWADDR = 4'h4;
    axi.S_AXI_WDATA  = 32'h5A5A0F0F;
    axi.S_AXI_WSTRB  = 4'hF;
    axi.S_AXI_BREADY = 1'b0;
    drive_aw_w(1'b1, 1'b1);
    @(posedge clk); #1;
    axi.S_AXI_ARADDR  = 4'h0;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY  = 1'b0;
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    n_cmp++;
    if ({axi.S_AXI_BVALID, axi.S_AXI_RVALID} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_setup: bvalid/rvalid got %b required 11", {axi.S_AXI_BVALID, axi.S_AXI_RVALID});
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if ({axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_AWREADY, axi.S_AXI_ARREADY} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_reset_flags: got %b required 0000",
               {axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_AWREADY, axi.S_AXI_ARREADY});
    end
    n_cmp++;
    if ({cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3} !== 128'h0) begin
      n_bad++;
      $display("FAIL mid_reset_cfg: got %h %h %h %h required 0", cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, resp);
      n_cmp++;
      if (rd !== m_shadow[i]) begin
        n_bad++;
        $display("FAIL post_reset_read[%0d]: got %h required %h", i, rd, m_shadow[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    frame_sync = 1'b0;
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWPROT  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARPROT  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;
    m_reset();
    test_reset();
    test_readback();
    test_strobes();
    test_channel_order();
    test_shadow_active();
    test_write_fsync();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
